// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the instruction encoder/loader: class codes,
// fixed opcode fields, opcode-group prefixes and FSM states.
package instr_encoder_loader_pkg;

  localparam logic [2:0] CLS_R      = 3'd0;
  localparam logic [2:0] CLS_I      = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JUMP   = 3'd5;

  localparam logic [5:0] OP_R = 6'b000000;
  localparam logic [5:0] OP_J = 6'b000010;

  // Upper three opcode bits that identify each I-format class
  localparam logic [2:0] OPG_I      = 3'b001;
  localparam logic [2:0] OPG_LOAD   = 3'b100;
  localparam logic [2:0] OPG_STORE  = 3'b101;
  localparam logic [2:0] OPG_BRANCH = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational packing of instruction fields into a 32-bit MIPS word,
// plus the legality check matching the control unit's class decode.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  // Select the format by class and check the opcode belongs to that class
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (cls)
      CLS_R: begin
        word  = {OP_R, rs, rt, rd, shamt, op};
        // funct 0 is only allowed as the all-zero NOP
        legal = (op != OP_R) || ({rs, rt, rd, shamt} == '0);
      end
      CLS_I: begin
        word  = {op, rs, rt, imm};
        legal = (op[5:3] == OPG_I);
      end
      CLS_LOAD: begin
        word  = {op, rs, rt, imm};
        legal = (op[5:3] == OPG_LOAD);
      end
      CLS_STORE: begin
        word  = {op, rs, rt, imm};
        legal = (op[5:3] == OPG_STORE);
      end
      CLS_BRANCH: begin
        word  = {op, rs, rt, imm};
        legal = (op[5:3] == OPG_BRANCH) && op[2] && !op[1];
      end
      CLS_JUMP: begin
        word  = {OP_J, target};
        legal = 1'b1;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads encoded instruction words sequentially into instruction memory.
// One bundle is accepted, then written on the following cycle.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state;
  state_t              state_nx;
  logic [31:0]         enc_word;
  logic                enc_legal;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     cnt;
  logic [31:0]         wdata;
  logic                last_q;
  logic                err_q;
  logic                ovf_q;

  instr_field_packer u_packer (
    .cls    (in_class),
    .op     (in_op),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .imm    (in_imm),
    .target (in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and state-derived strobes
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_ACCEPT;
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (enc_legal)    state_nx = S_WRITE;
          else if (in_last) state_nx = S_DONE;
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        // in_last takes priority, so a final word in the last slot is not an overflow
        if (last_q || (addr == LAST_ADDR)) state_nx = S_DONE;
        else                               state_nx = S_ACCEPT;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nx = S_ACCEPT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Address/count progression, captured word and sticky session flags
  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= BASE;
      cnt    <= '0;
      wdata  <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr  <= BASE;
            cnt   <= '0;
            err_q <= 1'b0;
            ovf_q <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            if (enc_legal) begin
              wdata  <= enc_word;
              last_q <= in_last;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          addr <= addr + 1'b1;
          cnt  <= cnt + 1'b1;
          if (!last_q && (addr == LAST_ADDR)) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = addr;
  assign imem_wdata = wdata;
  assign err        = err_q;
  assign overflow   = ovf_q;
  assign count      = cnt;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: a transaction-level model
// compared every cycle, plus literal checks on the words actually written.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic        in_valid;
  logic [2:0]  in_class;
  logic [5:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  logic        rdy0, we0, done0, err0, ovf0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic [8:0]  cnt0;

  logic        rdy1, we1, done1, err1, ovf1;
  logic [1:0]  addr1;
  logic [31:0] wdata1;
  logic [2:0]  cnt1;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid), .in_ready(rdy0),
    .in_class(in_class), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .done(done0),
    .err(err0), .overflow(ovf0), .count(cnt0)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_ready(rdy1),
    .in_class(in_class), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .done(done1),
    .err(err1), .overflow(ovf1), .count(cnt1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the field layouts, using arithmetic on ints
  function automatic void ref_enc(input int cls, input int op, input int rs, input int rt,
                                  input int rd, input int sh, input int imm, input int tgt,
                                  output logic [31:0] w, output bit ok);
    w  = 32'd0;
    ok = 1'b0;
    case (cls)
      0: begin
        w  = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(op);
        ok = (op != 0) || (rs + rt + rd + sh == 0);
      end
      1, 2, 3, 4: begin
        w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        case (cls)
          1:       ok = (op / 8 == 1);
          2:       ok = (op / 8 == 4);
          3:       ok = (op / 8 == 5);
          default: ok = (op / 8 == 0) && (op % 8 == 4 || op % 8 == 5);
        endcase
      end
      5: begin
        w  = (32'd2 << 26) | 32'(tgt);
        ok = 1'b1;
      end
      default: ok = 1'b0;
    endcase
  endfunction

  // Model: mode 0 idle, 1 taking a bundle, 2 writing, 3 finished
  int          m_mode [2];
  int          m_addr [2];
  int          m_cnt  [2];
  bit          m_err  [2];
  bit          m_ovf  [2];
  bit          m_last [2];
  logic [31:0] m_data [2];
  int          cap    [2] = '{256, 4};

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_addr[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
      m_ovf[d] = 0; m_last[d] = 0; m_data[d] = 32'd0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [31:0] w;
      bit          ok;
      bit          st;
      st = (d == 0) ? start0 : start1;
      ref_enc(int'(in_class), int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd),
              int'(in_shamt), int'(in_imm), int'(in_target), w, ok);
      if (rst) begin
        m_mode[d] <= 0; m_addr[d] <= 0; m_cnt[d] <= 0; m_err[d] <= 0;
        m_ovf[d] <= 0; m_last[d] <= 0; m_data[d] <= 32'd0;
      end else if (m_mode[d] == 2) begin
        m_addr[d] <= (m_addr[d] + 1) % cap[d];
        m_cnt[d]  <= m_cnt[d] + 1;
        if (m_last[d]) m_mode[d] <= 3;
        else if (m_addr[d] == cap[d] - 1) begin
          m_ovf[d]  <= 1;
          m_mode[d] <= 3;
        end else m_mode[d] <= 1;
      end else if (m_mode[d] == 1) begin
        if (in_valid) begin
          if (ok) begin
            m_data[d] <= w;
            m_last[d] <= in_last;
            m_mode[d] <= 2;
          end else begin
            m_err[d] <= 1;
            if (in_last) m_mode[d] <= 3;
          end
        end
      end else if (st) begin
        m_mode[d] <= 1; m_addr[d] <= 0; m_cnt[d] <= 0; m_err[d] <= 0; m_ovf[d] <= 0;
      end
    end
  end

  logic [39:0] log0[$];
  logic [39:0] log1[$];

  // Cycle compare against the model, and record every write actually issued
  always @(negedge clk) begin
    chk("ready0", 40'(rdy0),   40'(m_mode[0] == 1));
    chk("we0",    40'(we0),    40'(m_mode[0] == 2));
    chk("done0",  40'(done0),  40'(m_mode[0] == 3));
    chk("addr0",  40'(addr0),  40'(m_addr[0]));
    chk("wdata0", 40'(wdata0), 40'(m_data[0]));
    chk("err0",   40'(err0),   40'(m_err[0]));
    chk("ovf0",   40'(ovf0),   40'(m_ovf[0]));
    chk("count0", 40'(cnt0),   40'(m_cnt[0]));
    chk("ready1", 40'(rdy1),   40'(m_mode[1] == 1));
    chk("we1",    40'(we1),    40'(m_mode[1] == 2));
    chk("done1",  40'(done1),  40'(m_mode[1] == 3));
    chk("addr1",  40'(addr1),  40'(m_addr[1]));
    chk("wdata1", 40'(wdata1), 40'(m_data[1]));
    chk("err1",   40'(err1),   40'(m_err[1]));
    chk("ovf1",   40'(ovf1),   40'(m_ovf[1]));
    chk("count1", 40'(cnt1),   40'(m_cnt[1]));
    if (we0) log0.push_back({addr0, wdata0});
    if (we1) log1.push_back({6'd0, addr1, wdata1});
  end

  task automatic pulse(input int d);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Present one bundle (called at a negedge); bounded wait for the handshake
  task automatic send(input int d, input int cls, input int op, input int rs, input int rt,
                      input int rd, input int sh, input int imm, input int tgt,
                      input bit last, input bit expect_acc);
    bit acc;
    acc       = 1'b0;
    in_class  = 3'(cls);
    in_op     = 6'(op);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_imm    = 16'(imm);
    in_target = 26'(tgt);
    in_last   = last;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((d == 0) ? rdy0 : rdy1) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) @(negedge clk);
    in_valid = 1'b0;
    chk("accepted", 40'(acc), 40'(expect_acc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0;
    in_class = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0; in_target = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 40'(rdy0), 40'd0);
    chk("rst_addr",  40'(addr0), 40'd0);
    chk("rst_count", 40'(cnt0), 40'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single R-type add, last
    pulse(0);
    send(0, 0, 'h20, 1, 2, 3, 0, 0, 0, 1, 1);
    repeat (2) @(negedge clk);
    chk("add_nwr",  40'(log0.size()), 40'd1);
    chk("add_word", log0[0], {8'd0, 32'h00221820});
    chk("add_done", 40'(done0), 40'd1);
    chk("add_cnt",  40'(cnt0), 40'd1);

    // addi / lw / sw sequence
    log0.delete();
    pulse(0);
    send(0, 1, 'h08, 0, 4, 0, 0, 'h0005, 0, 0, 1);
    send(0, 2, 'h23, 4, 5, 0, 0, 'h0004, 0, 0, 1);
    send(0, 3, 'h2B, 4, 5, 0, 0, 'h0008, 0, 1, 1);
    repeat (2) @(negedge clk);
    chk("seq_nwr", 40'(log0.size()), 40'd3);
    chk("seq_w0",  log0[0], {8'd0, 32'h20040005});
    chk("seq_w1",  log0[1], {8'd1, 32'h8C850004});
    chk("seq_w2",  log0[2], {8'd2, 32'hAC850008});
    chk("seq_cnt", 40'(cnt0), 40'd3);

    // Illegal branch opcode, then a legal beq
    log0.delete();
    pulse(0);
    send(0, 4, 'h06, 1, 2, 0, 0, 3, 0, 0, 1);
    chk("bad_err",   40'(err0), 40'd1);
    chk("bad_ready", 40'(rdy0), 40'd1);
    chk("bad_nwr",   40'(log0.size()), 40'd0);
    send(0, 4, 'h04, 1, 2, 0, 0, 3, 0, 1, 1);
    repeat (2) @(negedge clk);
    chk("beq_word", log0[0], {8'd0, 32'h10220003});
    chk("beq_err",  40'(err0), 40'd1);

    // Jump ignores in_op
    log0.delete();
    pulse(0);
    send(0, 5, 'h3F, 0, 0, 0, 0, 0, 'h100, 1, 1);
    repeat (2) @(negedge clk);
    chk("j_word", log0[0], {8'd0, 32'h08000100});
    chk("j_err",  40'(err0), 40'd0);

    // NOP is legal, R funct 0 with fields is not, class 6 illegal and last
    log0.delete();
    pulse(0);
    send(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    send(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    send(0, 6, 'h08, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (2) @(negedge clk);
    chk("nop_nwr",  40'(log0.size()), 40'd1);
    chk("nop_word", log0[0], {8'd0, 32'h00000000});
    chk("nop_done", 40'(done0), 40'd1);
    chk("nop_cnt",  40'(cnt0), 40'd1);

    // Overflow on the 4-word instance
    pulse(1);
    for (int i = 0; i < 4; i++) send(1, 0, 'h20, 0, 0, i, 0, 0, 0, 0, 1);
    send(1, 0, 'h20, 0, 0, 7, 0, 0, 0, 0, 0);
    chk("ovf_flag", 40'(ovf1), 40'd1);
    chk("ovf_done", 40'(done1), 40'd1);
    chk("ovf_cnt",  40'(cnt1), 40'd4);
    chk("ovf_nwr",  40'(log1.size()), 40'd4);
    chk("ovf_w0",   log1[0], {8'd0, 32'h00000020});
    chk("ovf_w3",   log1[3], {8'd3, 32'h00001820});

    // Reset while a write is in progress
    pulse(0);
    send(0, 1, 'h08, 0, 4, 0, 0, 'h0005, 0, 0, 1);
    chk("mid_we", 40'(we0), 40'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_we",    40'(we0), 40'd0);
    chk("rst_cnt2",  40'(cnt0), 40'd0);
    chk("rst_wdata", 40'(wdata0), 40'd0);
    rst = 1'b0;
    log0.delete();
    @(negedge clk);
    pulse(0);
    send(0, 0, 'h20, 1, 2, 3, 0, 0, 0, 1, 1);
    repeat (2) @(negedge clk);
    chk("resume_nwr",  40'(log0.size()), 40'd1);
    chk("resume_word", log0[0], {8'd0, 32'h00221820});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encodes instruction fields into 32-bit MIPS instruction words and writes them sequentially into instruction memory before the pipeline runs. Each opcode is checked against the same class rules the control unit uses to decode it, so every stored word decodes to the intended Branch/MemWrite/RegWrite/ALUSrc behaviour. The block sits between the test/boot host and the instruction memory write port.

Parameters:
ADDR_W, 8, instruction memory word-address width; capacity is 2**ADDR_W words.
BASE_ADDR, 0, first word address written after start.

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
start  in  1  pulse; begins a load session from BASE_ADDR
in_valid  in  1  field bundle valid
in_ready  out  1  block accepts a bundle this cycle
in_class  in  3  0=R, 1=I, 2=LOAD, 3=STORE, 4=BRANCH, 5=JUMP; 6–7 illegal
in_op  in  6  funct for R class, opcode otherwise
in_rs / in_rt / in_rd  in  5 each  register fields
in_shamt  in  5  shift amount (R only)
in_imm  in  16  immediate/offset (I, LOAD, STORE, BRANCH)
in_target  in  26  jump target (JUMP)
in_last  in  1  bundle is the final instruction of the session
imem_we  out  1  memory write strobe
imem_addr  out  ADDR_W  memory word address
imem_wdata  out  32  encoded instruction
done  out  1  session finished
err  out  1  sticky: an illegal bundle was seen this session
overflow  out  1  sticky: memory filled before in_last
count  out  ADDR_W+1  words written this session

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, done=0, err=0, overflow=0, count=0. FSM enters IDLE. Reset mid-session aborts the session and writes nothing further.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE: in_ready=0. On start, go to ACCEPT and clear addr, count, err, overflow and done.
- ACCEPT: in_ready=1. On in_valid, register the encoded word and the in_last flag, then go to WRITE.
- WRITE: imem_we=1 for exactly one cycle with the registered address and data. Then increment addr and count.
  - If the captured in_last was set, go to DONE.
  - Else if addr was 2**ADDR_W-1, set overflow and go to DONE.
  - Else return to ACCEPT.
- Latency and throughput: imem_we asserts the cycle after the handshake. Maximum throughput is one word per two cycles.
- Illegal bundle: set err and skip WRITE. addr and count are unchanged. If in_last is set, go to DONE; otherwise stay in ACCEPT.
- DONE: done=1, in_ready=0. A new start restarts the session.
- start is ignored outside IDLE and DONE.
- Encoding (op = in_op):
  - R: {6'b0, rs, rt, rd, shamt, op}. Legal if op != 6'b0 or all fields are zero, so all-zero is a NOP.
  - I: {op, rs, rt, imm}. Legal iff op[5:3]=3'b001.
  - LOAD: {op, rs, rt, imm}. Legal iff op[5:3]=3'b100.
  - STORE: {op, rs, rt, imm}. Legal iff op[5:3]=3'b101.
  - BRANCH: {op, rs, rt, imm}. Legal iff op[5:3]=3'b000, op[2]=1 and op[1]=0.
  - JUMP: {6'b000010, target}. in_op is ignored.
  - in_class 6–7 is always illegal.
- Encoding is combinational from the inputs and registered only on the handshake.

Decomposition:
- Shared package: class codes, opcode field constants (OP_R=6'b000000, OP_J=6'b000010), and FSM state encodings.
- One natural sub-module, instr_field_packer: purely combinational fields→word packing plus the legality check. The FSM, counters and sticky flags stay in the top module.

Test Plan:
- start, then R bundle rs=1, rt=2, rd=3, shamt=0, op=6'h20, last=1 → one write: addr 0, data 32'h00221820; done=1; count=1.
- I addi op=6'h08, rs=0, rt=4, imm=16'h0005; then LOAD op=6'h23, rs=4, rt=5, imm=4; then STORE op=6'h2B with last=1 → data 20040005, 8C850004, then AC…; addrs 0, 1, 2; count=3.
- BRANCH with op=6'h06 (op[1]=1) → err=1, no imem_we, in_ready stays 1. The next legal beq op=6'h04 is written at addr 0.
- ADDR_W=2, five bundles with no last → four writes at addrs 0–3, overflow=1, done=1, fifth bundle never accepted.
- JUMP target=26'h0000100 with in_op=6'h3F → data 32'h08000100.
- rst asserted during WRITE → imem_we=0 next cycle and all outputs at reset values. start after rst → writing resumes at BASE_ADDR.
